quad_decoder: RTL

Quadrature decoder that produces the `up`/`down` step strobes consumed by the team's up/down counter. It samples the two asynchronous encoder channels, synchronizes and glitch-filters them, and tracks the Gray-code phase. Each legal phase step becomes a single-cycle `up` or `down` pulse. Illegal double-bit jumps are flagged and counted.

---
 rtl/quad_decoder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature decoder producing one-cycle up/down step strobes.
//
// Both encoder channels are synchronized with a two-flop chain, glitch-filtered
// (a new level must hold for FILT cycles before it is accepted), and the filtered
// Gray-code phase {fa, fb} is compared with its previous value to classify each
// change as a forward step, a reverse step or an illegal double-bit jump.
//
// Parameters:
//   FILT    - stability cycles required by the channel filter (1..15)
//   WIDTH   - width of the saturating illegal-transition counter
// Ports:
//   clk     - clock, all logic on the rising edge
//   rst     - synchronous active-high reset
//   en      - enables pulse generation and error counting
//   a_in    - encoder channel A (asynchronous)
//   b_in    - encoder channel B (asynchronous)
//   clr_err - synchronous clear of err_cnt (wins over an increment)
//   up      - one-cycle pulse per forward step
//   down    - one-cycle pulse per reverse step
//   dir     - last legal direction, 1 = forward
//   err     - one-cycle pulse per illegal transition
//   err_cnt - saturating count of illegal transitions
module quad_decoder #(
  parameter int unsigned FILT  = 3,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_err,
  output logic             up,
  output logic             down,
  output logic             dir,
  output logic             err,
  output logic [WIDTH-1:0] err_cnt
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // Counter value on the last mismatch cycle before the new level is accepted.
  localparam logic [3:0]       FiltLast = 4'(FILT - 1);
  localparam logic [WIDTH-1:0] CntMax   = '1;
  localparam logic [WIDTH-1:0] CntOne   = WIDTH'(1);

  // Synchronizers
  logic a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  // Filters
  logic       fa_q, fa_d, fb_q, fb_d;
  logic [3:0] fa_cnt_q, fa_cnt_d, fb_cnt_q, fb_cnt_d;

  // Phase tracking and control
  logic [1:0] prev_q, prev_d;
  logic [0:0] state_q, state_d;
  logic [1:0] init_cnt_q, init_cnt_d;

  // Registered outputs
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Phase classification
  logic [1:0] cur;
  logic [1:0] cur_pos, prev_pos, step;
  logic       is_fwd, is_rev, is_ill;

  // Gray to binary position: 00->0, 01->1, 11->2, 10->3. A forward step adds 1,
  // a reverse step subtracts 1, a jump of 2 means both bits flipped.
  assign cur      = {fa_q, fb_q};
  assign cur_pos  = {cur[1], cur[1] ^ cur[0]};
  assign prev_pos = {prev_q[1], prev_q[1] ^ prev_q[0]};
  assign step     = cur_pos - prev_pos;
  assign is_fwd   = (step == 2'd1);
  assign is_rev   = (step == 2'd3);
  assign is_ill   = (step == 2'd2);

  always_comb begin
    fa_d       = fa_q;
    fb_d       = fb_q;
    fa_cnt_d   = fa_cnt_q;
    fb_cnt_d   = fb_cnt_q;
    prev_d     = prev_q;
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      StInit: begin
        fa_cnt_d = '0;
        fb_cnt_d = '0;
        // Wait for the synchronizers to fill, then adopt the channel levels
        // as-is so a static non-zero encoder position is not seen as a step.
        if (init_cnt_q == 2'd2) begin
          fa_d    = a_s2_q;
          fb_d    = b_s2_q;
          prev_d  = {a_s2_q, b_s2_q};
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end

      StRun: begin
        // Channel A filter
        if (a_s2_q != fa_q) begin
          if (fa_cnt_q == FiltLast) begin
            fa_d     = a_s2_q;
            fa_cnt_d = '0;
          end else begin
            fa_cnt_d = fa_cnt_q + 4'd1;
          end
        end else begin
          fa_cnt_d = '0;
        end

        // Channel B filter
        if (b_s2_q != fb_q) begin
          if (fb_cnt_q == FiltLast) begin
            fb_d     = b_s2_q;
            fb_cnt_d = '0;
          end else begin
            fb_cnt_d = fb_cnt_q + 4'd1;
          end
        end else begin
          fb_cnt_d = '0;
        end

        // prev tracks even while disabled so re-enabling is glitch-free.
        prev_d = cur;
        up_d   = en & is_fwd;
        down_d = en & is_rev;
        err_d  = en & is_ill;

        if (up_d) begin
          dir_d = 1'b1;
        end else if (down_d) begin
          dir_d = 1'b0;
        end

        if (err_d && (err_cnt_q != CntMax)) begin
          err_cnt_d = err_cnt_q + CntOne;
        end
      end

      default: state_d = StInit;
    endcase

    if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1_q     <= 1'b0;
      a_s2_q     <= 1'b0;
      b_s1_q     <= 1'b0;
      b_s2_q     <= 1'b0;
      fa_q       <= 1'b0;
      fb_q       <= 1'b0;
      fa_cnt_q   <= '0;
      fb_cnt_q   <= '0;
      prev_q     <= '0;
      state_q    <= StInit;
      init_cnt_q <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
      dir_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      a_s1_q     <= a_in;
      a_s2_q     <= a_s1_q;
      b_s1_q     <= b_in;
      b_s2_q     <= b_s1_q;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fa_cnt_q   <= fa_cnt_d;
      fb_cnt_q   <= fb_cnt_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      up_q       <= up_d;
      down_q     <= down_d;
      err_q      <= err_d;
      dir_q      <= dir_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign up      = up_q;
  assign down    = down_q;
  assign err     = err_q;
  assign dir     = dir_q;
  assign err_cnt = err_cnt_q;

endmodule
